// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
//   mdu_op_t    : operation encoding driven by control on the op port
//   mdu_state_t : sequencer states of mult_div_unit
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX
    } mdu_state_t;

    // op[0]==0 selects the signed variant, op[1]==1 selects divide
    localparam int MDU_OP_SIGNED_BIT = 0;
    localparam int MDU_OP_DIV_BIT    = 1;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the iterative multiply/divide engine (purely combinational).
//   acc     in  : 2*WIDTH accumulator
//                 multiply: {partial product, remaining multiplier bits}
//                 divide  : {partial remainder, dividend bits / quotient bits}
//   operand in  : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   is_div  in  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_nxt out : accumulator after this step (divide: bit 0 left clear)
//   q_bit   out : quotient bit produced by a divide step (0 for multiply)
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] rem_sub;
    logic           rem_ge;

    always_comb begin
        // Multiply: add the multiplicand into the upper half when the current
        // multiplier LSB is set; the carry is kept and shifted down with the rest.
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
        // Divide: remainder after the left shift needs one extra bit so the
        // unsigned compare against a full-range divisor cannot overflow.
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        rem_sub = rem_sh - {1'b0, operand};
        rem_ge  = (rem_sh >= {1'b0, operand});

        if (is_div) begin
            acc_nxt = {(rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
            q_bit   = rem_ge;
        end else begin
            acc_nxt = {sum, acc[WIDTH-1:1]};
            q_bit   = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Runs MULT/MULTU/DIV/DIVU one bit per cycle and accepts MTHI/MTLO writes.
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   start, op, a, b   : issue request (accepted only while idle)
//   wr_hi, wr_lo      : MTHI/MTLO, write a into hi/lo (idle only)
//   busy              : op in flight, pipeline must stall
//   done, div_zero    : completion pulse; div_zero qualifies a DIV/DIVU by zero
//   hi, lo            : architectural HI/LO
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    mdu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               sgn_quo_q, sgn_quo_d;
    logic               sgn_rem_q, sgn_rem_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_div, is_sgn;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] step_acc, res;
    logic               step_q;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div = op_q[MDU_OP_DIV_BIT];
    assign is_sgn = ~op_q[MDU_OP_SIGNED_BIT];

    // The most negative value negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign abs_a = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    assign abs_b = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .acc     (acc_q),
        .operand (opnd_q),
        .is_div  (is_div),
        .acc_nxt (step_acc),
        .q_bit   (step_q)
    );

    assign res      = step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
    assign prod_fix = sgn_quo_q ? -res : res;
    assign quo_fix  = sgn_quo_q ? -res[WIDTH-1:0] : res[WIDTH-1:0];
    assign rem_fix  = sgn_rem_q ? -res[2*WIDTH-1:WIDTH] : res[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            ST_IDLE: begin
                // MT writes and an accepted start may coincide; FIX overwrites later.
                if (wr_hi) hi_d = a;
                if (wr_lo) lo_d = a;
                if (start) begin
                    op_d    = mdu_op_t'(op);
                    a_d     = a;
                    b_d     = b;
                    state_d = ST_PREP;
                end
            end
            ST_PREP: begin
                // Multiply keeps the multiplier in the low half, divide the dividend.
                acc_d     = {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                opnd_d    = is_div ? abs_b : abs_a;
                sgn_quo_d = is_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                sgn_rem_d = is_sgn & a_q[WIDTH-1];
                dz_d      = is_div & (b_q == {WIDTH{1'b0}});
                cnt_d     = CNT_W'(WIDTH);
                state_d   = ST_RUN;
            end
            ST_RUN: begin
                acc_d = res;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Sign-fixed result lands on the edge into FIX so hi/lo are
                    // already valid while done is high.
                    if (dz_q) begin
                        hi_d = a_q;
                        lo_d = {WIDTH{1'b1}};
                    end else if (is_div) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            op_q      <= MDU_MULT;
            a_q       <= '0;
            b_q       <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FIX);
    assign div_zero = done & dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): directed cases plus
// randomized ops compared against a plain-arithmetic reference model.
module tb_mult_div_unit;

    logic        clk, reset, start, wr_hi, wr_lo;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .busy(busy), .done(done),
        .div_zero(div_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit arithmetic straight from the architectural definition.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic edz);
        longint      sx, sy;
        logic [63:0] p, q, r;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        edz = 1'b0;
        case (o)
            2'b00: begin p = sx * sy; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (y == 32'd0) begin
                    eh = x; el = 32'hFFFF_FFFF; edz = 1'b1;
                end else if (o == 2'b10) begin
                    q = sx / sy; r = sx % sy; eh = r[31:0]; el = q[31:0];
                end else begin
                    q = {32'b0, x} / {32'b0, y}; r = {32'b0, x} % {32'b0, y};
                    eh = r[31:0]; el = q[31:0];
                end
            end
        endcase
    endfunction

    // Issue one op and check the result; optional disturbances while busy.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input bit disturb, input bit mt_lo);
        int          n;
        logic [31:0] eh, el;
        logic        edz;
        model(o, x, y, eh, el, edz);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; wr_lo = mt_lo;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0; wr_lo = 1'b0;
        if (mt_lo) exp_lo = x;
        chk({nm, "_busy_rise"}, busy, 1);
        chk({nm, "_mt_lo"}, lo, exp_lo);
        while (!done && n < 100) begin
            if (disturb && n == 5) begin start = 1'b1; op = 2'b01; a = 32'd1; b = 32'd1; end
            if (disturb && n == 8) begin wr_lo = 1'b1; wr_hi = 1'b1; a = 32'hDEAD; end
            @(posedge clk);
            n++;
            @(negedge clk);
            start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
            if (n == 20) begin
                chk({nm, "_hold_hi"}, hi, exp_hi);
                chk({nm, "_hold_lo"}, lo, exp_lo);
            end
        end
        chk({nm, "_latency"}, 64'(n), 64'd34);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        chk({nm, "_dz"}, div_zero, edz);
        chk({nm, "_busy_fix"}, busy, 1);
        exp_hi = eh;
        exp_lo = el;
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_busy_fall"}, {busy, done}, 2'b00);
        chk({nm, "_keep_hi"}, hi, exp_hi);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, pulses;
        reset = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, div_zero, hi, lo}, 67'd0);
        reset = 1'b0;

        // MTHI in idle
        @(negedge clk);
        wr_hi = 1'b1; a = 32'hBEEF;
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0;
        exp_hi = 32'hBEEF;
        chk("mthi_hi", hi, exp_hi);
        chk("mthi_lo", lo, exp_lo);

        run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0);
        run_op("multu",    2'b01, 32'hFFFF_FFFE, 32'd3, 0, 0);
        run_op("div_neg",  2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
        run_op("divu",     2'b11, 32'd7, 32'd2, 0, 0);
        run_op("div_ovf",  2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op("divu_z",   2'b11, 32'd5, 32'd0, 0, 0);
        run_op("div_z",    2'b10, 32'hFFFF_FFF0, 32'd0, 0, 0);
        run_op("busy_ign", 2'b01, 32'd3, 32'd4, 1, 0);
        chk("busy_ign_lo12", lo, 32'd12);
        run_op("st_mtlo",  2'b11, 32'd100, 32'd7, 0, 1);

        // Reset mid-op: MULT 7*9, reset during RUN cycle 10
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd9;
        @(posedge clk);
        n = 1;
        @(negedge clk);
        start = 1'b0;
        while (n < 11) begin @(posedge clk); n++; @(negedge clk); end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid", {busy, hi, lo}, 65'd0);
        exp_hi = '0; exp_lo = '0;
        pulses = 0;
        repeat (40) begin @(posedge clk); @(negedge clk); if (done) pulses++; end
        chk("rst_no_done", 64'(pulses), 64'd0);
        chk("rst_keep", {hi, lo}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = pick();
            rb = pick();
            run_op("rand", ro, ra, rb, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
